uart_rx: RTL

Receive-side UART: recovers frames from the serial line and delivers parallel bytes to the core. It pairs with the team's UART transmitter and accepts exactly the frame that transmitter produces: 1 start bit (0), DATA_WIDTH data bits LSB first, an optional parity bit, and 1 stop bit (1). Bits are recovered by oversampling at `prescale` clocks per bit with majority voting, followed by framing and parity checks.

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_bit_sampler.sv | 44 ++++
 rtl/uart_rx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM states, prescale
// values, parity encoding and the 3-sample majority vote.
package uart_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  typedef enum logic {PARITY_EVEN = 1'b0, PARITY_ODD = 1'b1} parity_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Out-of-range ratios fall back to 16 so the edge counter always wraps.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    if (p == PRESCALE_8 || p == PRESCALE_16 || p == PRESCALE_32) return p;
    return PRESCALE_16;
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Per-bit oversampling: edge counter, three mid-bit samples and majority vote.
module rx_bit_sampler
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] prescale,
  input  logic       rx_s,
  output logic [5:0] edge_cnt,
  output logic       sampled_bit,
  output logic       sample_done
);

  logic [5:0] edge_cnt_q, edge_cnt_d;
  logic [2:0] samp_q, samp_d;
  logic [5:0] half;

  assign half = prescale >> 1;

  always_comb begin
    edge_cnt_d = 6'd0;
    if (run) edge_cnt_d = (edge_cnt_q == prescale - 6'd1) ? 6'd0 : edge_cnt_q + 6'd1;
    samp_d = samp_q;
    if (edge_cnt_q == half - 6'd1) samp_d[0] = rx_s;
    if (edge_cnt_q == half)        samp_d[1] = rx_s;
    if (edge_cnt_q == half + 6'd1) samp_d[2] = rx_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= 6'd0;
      samp_q     <= 3'b111;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      samp_q     <= samp_d;
    end
  end

  assign edge_cnt    = edge_cnt_q;
  assign sampled_bit = maj3(samp_q);
  assign sample_done = (edge_cnt_q == half + 6'd2);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, shift register, parity/stop checks
// and single-cycle registered result pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [5:0]            prescale,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [1:0]            sync_q, sync_d;
  rx_state_e             state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic [5:0]            pre_q, pre_d;
  logic                  pen_q, pen_d;
  parity_e               ptype_q, ptype_d;
  logic                  perr_q, perr_d, serr_q, serr_d;
  logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;

  logic       rx_s, run, bit_end, sampled_bit, sample_done, exp_par;
  logic [5:0] edge_cnt;

  assign sync_d  = {sync_q[0], RX_IN};
  assign rx_s    = sync_q[1];
  assign bit_end = (edge_cnt == pre_q - 6'd1);
  assign exp_par = (ptype_q == PARITY_EVEN) ? ^shreg_q : ~^shreg_q;

  rx_bit_sampler u_sampler (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .prescale    (pre_q),
    .rx_s        (rx_s),
    .edge_cnt    (edge_cnt),
    .sampled_bit (sampled_bit),
    .sample_done (sample_done)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    pdata_d   = pdata_q;
    pre_d     = pre_q;
    pen_d     = pen_q;
    ptype_d   = ptype_q;
    perr_d    = perr_q;
    serr_d    = serr_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;
    run       = 1'b1;
    case (state_q)
      IDLE: begin
        run = ~rx_s;
        if (!rx_s) begin
          state_d   = START;
          pre_d     = legal_prescale(prescale);
          pen_d     = parity_enable;
          ptype_d   = parity_e'(parity_type);
          perr_d    = 1'b0;
          serr_d    = 1'b0;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (sample_done && sampled_bit) begin
          // Start bit did not hold low through mid-bit: treat as noise.
          state_d = IDLE;
          run     = 1'b0;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (sample_done) shreg_d = {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = pen_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      PARITY: begin
        if (sample_done) perr_d = (exp_par != sampled_bit);
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (sample_done) serr_d = ~sampled_bit;
        if (bit_end) begin
          state_d = IDLE;
          pe_d    = perr_q;
          se_d    = serr_q;
          if (!perr_q && !serr_q) begin
            dv_d    = 1'b1;
            pdata_d = shreg_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      pdata_q   <= '0;
      pre_q     <= PRESCALE_8;
      pen_q     <= 1'b0;
      ptype_q   <= PARITY_EVEN;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      pdata_q   <= pdata_d;
      pre_q     <= pre_d;
      pen_q     <= pen_d;
      ptype_q   <= ptype_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign P_DATA       = pdata_q;
  assign Data_Valid   = dv_q;
  assign parity_error = pe_q;
  assign stop_error   = se_q;

endmodule
